// File: rtl/paralelo_serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver):
// comma/idle character, default preamble length and FSM state encoding.
package paralelo_serial_pkg;

  // Idle / synchronisation character sent whenever no data byte is available
  localparam logic [7:0] COMMA_CHAR = 8'hBC;

  // Default number of comma bytes sent after reset before data is accepted
  localparam int SYNC_BCS_DEFAULT = 4;

  // Link state: preamble in progress, or carrying data/idle traffic
  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } ps_state_e;

endpackage : paralelo_serial_pkg

// File: rtl/ps_shift_core.sv
// 8-bit load/shift core of the parallel-to-serial transmitter.
// Emits cur_byte MSB first, one bit per clock, and reloads from load_byte_i
// on the edge where the 3-bit bit counter sits at 7, so bytes follow each
// other with no gap bits.
module ps_shift_core #(
  parameter logic [7:0] RST_BYTE = 8'hBC
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] load_byte_i,
  output logic       boundary_o,
  output logic       serial_o
);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] cur_byte_q, cur_byte_d;
  logic       serial_q, serial_d;

  // Byte boundary is a pure decode of the registered bit counter
  always_comb begin
    boundary_o = (bit_cnt_q == 3'd7);
  end

  // Next-state: shift one bit out, advance the counter, reload at the boundary
  always_comb begin
    serial_d   = cur_byte_q[3'd7 - bit_cnt_q];
    bit_cnt_d  = bit_cnt_q + 3'd1;
    cur_byte_d = cur_byte_q;
    if (bit_cnt_q == 3'd7) begin
      cur_byte_d = load_byte_i;
    end else begin
      cur_byte_d = cur_byte_q;
    end
  end

  // Shift register, bit counter and registered serial output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q  <= 3'd0;
      cur_byte_q <= RST_BYTE;
      serial_q   <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      cur_byte_q <= cur_byte_d;
      serial_q   <= serial_d;
    end
  end

  assign serial_o = serial_q;

endmodule : ps_shift_core

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter, top level.
// After reset sends SYNC_BCS comma bytes, then serializes bytes taken over a
// valid/ready handshake, filling idle slots with COMMA.
// Optional build macro PARALELO_SERIAL_BYTE_CNT_EN adds a saturating 16-bit
// count of accepted data bytes on tx_byte_cnt_PS.
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter int         SYNC_BCS = SYNC_BCS_DEFAULT,
  parameter logic [7:0] COMMA    = COMMA_CHAR
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_in_PS,
  input  logic        valid_in_PS,
  output logic        ready_PS,
  output logic        data_out_PS,
  output logic        active_PS
`ifdef PARALELO_SERIAL_BYTE_CNT_EN
  ,
  output logic [15:0] tx_byte_cnt_PS
`endif
);

  // Preamble counter value at which the last comma boundary is reached
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BCS - 1);

  ps_state_e  state_q, state_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       active_q, active_d;
  logic       boundary_s;
  logic       accept_s;
  logic [7:0] load_byte_s;

  ps_shift_core #(
    .RST_BYTE (COMMA)
  ) u_core (
    .clk_i       (clk_32f),
    .rst_i       (reset),
    .load_byte_i (load_byte_s),
    .boundary_o  (boundary_s),
    .serial_o    (data_out_PS)
  );

  // Handshake decode from registered state only (no path from valid_in_PS)
  always_comb begin
    ready_PS = boundary_s & ((state_q == DATA) | (sync_cnt_q == SYNC_LAST));
    accept_s = valid_in_PS & ready_PS;
    if (accept_s) begin
      load_byte_s = data_in_PS;
    end else begin
      load_byte_s = COMMA;
    end
  end

  // FSM next state: count preamble commas, then stay in DATA until reset
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    active_d   = active_q;
    case (state_q)
      SYNC: begin
        if (boundary_s) begin
          if (sync_cnt_q == SYNC_LAST) begin
            state_d  = DATA;
            active_d = 1'b1;
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end else begin
          sync_cnt_d = sync_cnt_q;
        end
      end
      DATA: begin
        state_d  = DATA;
        active_d = 1'b1;
      end
      default: begin
        state_d    = SYNC;
        sync_cnt_d = 4'd0;
        active_d   = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      sync_cnt_q <= 4'd0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      active_q   <= active_d;
    end
  end

  assign active_PS = active_q;

`ifdef PARALELO_SERIAL_BYTE_CNT_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  // Saturating count of accepted data bytes (commas are never counted)
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (accept_s && (byte_cnt_q != 16'hFFFF)) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  // Byte counter register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      byte_cnt_q <= 16'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign tx_byte_cnt_PS = byte_cnt_q;
`endif

endmodule : paralelo_serial

// File: tb/tb_paralelo_serial.sv
// Directed testbench for paralelo_serial: expected line bits come from a
// per-scenario list of hand-written bytes, expected ready/active from the
// fixed preamble timing (SYNC_BCS = 4).
module tb_paralelo_serial;

  logic        clk_32f = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in_PS = 8'h00;
  logic        valid_in_PS = 1'b0;
  logic        ready_PS;
  logic        data_out_PS;
  logic        active_PS;
`ifdef PARALELO_SERIAL_BYTE_CNT_EN
  logic [15:0] tx_byte_cnt_PS;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [7:0] exp_q[$];

  paralelo_serial dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in_PS  (data_in_PS),
    .valid_in_PS (valid_in_PS),
    .ready_PS    (ready_PS),
    .data_out_PS (data_out_PS),
    .active_PS   (active_PS)
`ifdef PARALELO_SERIAL_BYTE_CNT_EN
    ,
    .tx_byte_cnt_PS (tx_byte_cnt_PS)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected line bit in cycle k (k>=1): byte (k-1)/8, MSB first
  function automatic logic exp_bit(input int k);
    int         idx;
    int         b;
    logic [7:0] v;
    idx = (k - 1) / 8;
    b   = 7 - ((k - 1) % 8);
    v   = exp_q[idx];
    return v[b];
  endfunction

  // Hold reset across two edges, check reset values, release #1 after an edge
  task automatic do_reset();
    reset       = 1'b1;
    valid_in_PS = 1'b0;
    data_in_PS  = 8'h00;
    repeat (2) @(posedge clk_32f);
    #1;
    chk("rst_dout", {31'd0, data_out_PS}, 32'd0);
    chk("rst_active", {31'd0, active_PS}, 32'd0);
    chk("rst_ready", {31'd0, ready_PS}, 32'd0);
`ifdef PARALELO_SERIAL_BYTE_CNT_EN
    chk("rst_cnt", {16'd0, tx_byte_cnt_PS}, 32'd0);
`endif
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Advance one edge and check line bit, ready and active for that cycle
  task automatic tick_check();
    @(posedge clk_32f);
    #1;
    cyc++;
    chk("dout", {31'd0, data_out_PS}, {31'd0, exp_bit(cyc)});
    chk("ready", {31'd0, ready_PS}, {31'd0, ((cyc % 8) == 7) && (cyc >= 31)});
    chk("active", {31'd0, active_PS}, {31'd0, cyc >= 32});
  endtask

  initial begin
    // 1: idle after reset -> six commas, ready at 31/39/47, active after 32
    do_reset();
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    for (int i = 0; i < 48; i++) tick_check();

    // 2: A5 held valid from cycle 0; accepted at edge 32, then 3C at edge 40
    do_reset();
    valid_in_PS = 1'b1;
    data_in_PS  = 8'hA5;
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'h3C, 8'hBC, 8'hBC};
    for (int i = 0; i < 64; i++) begin
      tick_check();
      if (cyc == 32) data_in_PS = 8'h3C;
      if (cyc == 40) valid_in_PS = 1'b0;
    end

    // 3: single accept of 00, then a valid pulse while ready is low (ignored)
    do_reset();
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC};
    for (int i = 0; i < 56; i++) begin
      tick_check();
      if (cyc == 31) begin valid_in_PS = 1'b1; data_in_PS = 8'h00; end
      if (cyc == 32) valid_in_PS = 1'b0;
      if (cyc == 34) begin valid_in_PS = 1'b1; data_in_PS = 8'h55; end
      if (cyc == 36) valid_in_PS = 1'b0;
    end

    // 4: five back-to-back bytes including a data 0xBC; none lost
    do_reset();
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h5A, 8'h01, 8'h80, 8'hFF, 8'hBC};
    for (int i = 0; i < 80; i++) begin
      tick_check();
      if (cyc == 31) begin valid_in_PS = 1'b1; data_in_PS = 8'hBC; end
      if (cyc == 32) data_in_PS = 8'h5A;
      if (cyc == 40) data_in_PS = 8'h01;
      if (cyc == 48) data_in_PS = 8'h80;
      if (cyc == 56) data_in_PS = 8'hFF;
      if (cyc == 64) valid_in_PS = 1'b0;
    end
`ifdef PARALELO_SERIAL_BYTE_CNT_EN
    chk("byte_cnt", {16'd0, tx_byte_cnt_PS}, 32'd5);
`endif

    // 5: reset in the middle of data byte FF aborts at once, preamble restarts
    do_reset();
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hFF};
    for (int i = 0; i < 36; i++) begin
      tick_check();
      if (cyc == 31) begin valid_in_PS = 1'b1; data_in_PS = 8'hFF; end
      if (cyc == 32) valid_in_PS = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("abort_dout", {31'd0, data_out_PS}, 32'd0);
    chk("abort_active", {31'd0, active_PS}, 32'd0);
    chk("abort_ready", {31'd0, ready_PS}, 32'd0);
    do_reset();
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    for (int i = 0; i < 40; i++) tick_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_paralelo_serial
